// File: rtl/cnn_pkg.sv
// Shared CNN-accelerator definitions: weight-loader FSM encoding and default buffer depth.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cnn_pkg;

  // Weights per kernel; this is also the depth of the weight shift buffer.
  localparam int WGT_DEPTH_DEF = 4;

  // Width of one weight word.
  localparam int WGT_DATA_W = 8;

  // Weight-loader sequencing states.
  typedef enum logic [2:0] {
    WL_IDLE  = 3'd0,
    WL_FETCH = 3'd1,
    WL_DRAIN = 3'd2,
    WL_READY = 3'd3,
    WL_DONE  = 3'd4
  } wl_state_e;

endpackage

// File: rtl/wgt_load_ctrl.sv
// Weight loader: streams WGT_DEPTH words per kernel from weight memory into a shift buffer, one kernel at a time.
// Latency: first read in the cycle after start, kernel valid WGT_DEPTH+2 cycles after start, done one cycle after last compute_done.
// Backpressure: holds each loaded kernel in READY until compute_done; abort or reset cancels at any point.
module wgt_load_ctrl
  import cnn_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int KCNT_W    = 8,
  parameter int WGT_DEPTH = WGT_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [KCNT_W-1:0]            num_kernels,
  input  logic                         abort,
  input  logic                         compute_done,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic signed [WGT_DATA_W-1:0] mem_rdata,
  output logic                         wgt_read,
  output logic signed [WGT_DATA_W-1:0] wgt_input,
  output logic                         wgt_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int WIDX_W = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WGT_DEPTH - 1);
  localparam logic [ADDR_W-1:0] KSTRIDE   = ADDR_W'(WGT_DEPTH);

  wl_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [KCNT_W-1:0]   nk_q, nk_d;
  logic [KCNT_W-1:0]   kidx_q, kidx_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                rd_q, rd_d;
  logic [KCNT_W:0]     kidx_inc;
  logic [ADDR_W-1:0]   fetch_addr;

  // Kernel index plus one, one bit wider so the compare against num_kernels cannot overflow.
  assign kidx_inc = {1'b0, kidx_q} + (KCNT_W+1)'(1);

  // Word address within the flat weight image; wraps naturally at 2^ADDR_W.
  assign fetch_addr = base_q + ADDR_W'(kidx_q) * KSTRIDE + ADDR_W'(widx_q);

  // Next-state, counter and latch update logic; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    nk_d    = nk_q;
    kidx_d  = kidx_q;
    widx_d  = widx_q;
    rd_d    = 1'b0;

    case (state_q)
      WL_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          nk_d    = num_kernels;
          kidx_d  = '0;
          widx_d  = '0;
          state_d = (num_kernels == '0) ? WL_DONE : WL_FETCH;
        end
      end

      WL_FETCH: begin
        // A read issued this cycle returns data next cycle, so shift next cycle.
        rd_d = 1'b1;
        if (widx_q == WIDX_LAST) begin
          widx_d  = '0;
          state_d = WL_DRAIN;
        end else begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end

      WL_DRAIN: begin
        // Final word is shifted in during this cycle.
        state_d = WL_READY;
      end

      WL_READY: begin
        if (compute_done) begin
          kidx_d = kidx_inc[KCNT_W-1:0];
          if (kidx_inc < {1'b0, nk_q}) begin
            state_d = WL_FETCH;
          end else begin
            state_d = WL_DONE;
          end
        end
      end

      WL_DONE: begin
        state_d = WL_IDLE;
      end

      default: begin
        state_d = WL_IDLE;
      end
    endcase

    // Cancel: back to IDLE with no pending shift; a read in flight is simply discarded.
    if (abort) begin
      state_d = WL_IDLE;
      widx_d  = '0;
      rd_d    = 1'b0;
    end
  end

  // State, counters, latched inputs and the registered shift enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WL_IDLE;
      base_q  <= '0;
      nk_q    <= '0;
      kidx_q  <= '0;
      widx_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      nk_q    <= nk_d;
      kidx_q  <= kidx_d;
      widx_q  <= widx_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs are decoded from the registered state so they are glitch-free from reset.
  always_comb begin
    mem_rd_en = (state_q == WL_FETCH);
    mem_addr  = mem_rd_en ? fetch_addr : '0;
    wgt_read  = rd_q;
    wgt_input = mem_rdata;
    wgt_valid = (state_q == WL_READY);
    busy      = (state_q != WL_IDLE);
    done      = (state_q == WL_DONE);
  end

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Directed bench for wgt_load_ctrl with a 1-cycle-latency memory model and a shift-buffer model.
// Latency: not applicable.
// Backpressure: compute_done is driven by the scenario tasks.
module tb_wgt_load_ctrl;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [9:0]        base_addr;
  logic [7:0]        num_kernels;
  logic              abort;
  logic              compute_done;
  logic              mem_rd_en;
  logic [9:0]        mem_addr;
  logic signed [7:0] mem_rdata = '0;
  logic              wgt_read;
  logic signed [7:0] wgt_input;
  logic              wgt_valid;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the model block below.
  int                rd_cnt   = 0;
  int                done_cnt = 0;
  int                win_cnt  = 0;
  logic              vld_prev = 1'b0;
  logic [9:0]        addr_hist [64];
  logic signed [7:0] sbuf [4];

  wgt_load_ctrl #(.ADDR_W(10), .KCNT_W(8), .WGT_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_kernels  (num_kernels),
    .abort        (abort),
    .compute_done (compute_done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .wgt_read     (wgt_read),
    .wgt_input    (wgt_input),
    .wgt_valid    (wgt_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory (word = address[7:0], 1-cycle latency), shift buffer (enters stage 0) and event counters.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= $signed(mem_addr[7:0]);
      addr_hist[rd_cnt[5:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (wgt_read) begin
      sbuf[0] <= wgt_input;
      for (int i = 1; i < 4; i++) sbuf[i] <= sbuf[i-1];
    end
    if (done) done_cnt <= done_cnt + 1;
    vld_prev <= wgt_valid;
    if (wgt_valid && !vld_prev) win_cnt <= win_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (wgt_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; compute_done = 1'b0;
    base_addr = '0; num_kernels = '0;
    repeat (3) tick();
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
    checks++; if (wgt_read !== 1'b0) begin errors++; $display("FAIL reset_wgt_read: got %b want 0", wgt_read); end
    checks++; if ({wgt_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {wgt_valid, busy, done}); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_kernel();
    bit ok;
    int d0;
    d0 = done_cnt;
    base_addr = 10'h010; num_kernels = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en[%0d]: got %b want 1", i, mem_rd_en); end
      checks++; if (mem_addr !== 10'h010 + 10'(i)) begin errors++; $display("FAIL single_addr[%0d]: got %h want %h", i, mem_addr, 10'h010 + 10'(i)); end
      checks++; if (wgt_read !== (i > 0)) begin errors++; $display("FAIL single_wgt_read[%0d]: got %b want %b", i, wgt_read, (i > 0)); end
      tick();
    end
    checks++; if ({mem_rd_en, wgt_read, wgt_valid, busy} !== 4'b0101) begin errors++; $display("FAIL single_drain: got %b want 0101", {mem_rd_en, wgt_read, wgt_valid, busy}); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL single_idle_addr: got %h want 000", mem_addr); end
    tick();
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_valid_timeout: got %b want 1", ok); end
    checks++; if ({sbuf[3], sbuf[2], sbuf[1], sbuf[0]} !== 32'h10111213) begin errors++; $display("FAIL single_buffer: got %h want 10111213", {sbuf[3], sbuf[2], sbuf[1], sbuf[0]}); end
    repeat (3) tick();
    checks++; if ({wgt_valid, wgt_read, mem_rd_en} !== 3'b100) begin errors++; $display("FAIL single_hold: got %b want 100", {wgt_valid, wgt_read, mem_rd_en}); end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    checks++; if ({done, wgt_valid, busy} !== 3'b101) begin errors++; $display("FAIL single_done: got %b want 101", {done, wgt_valid, busy}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL single_after_done: got %b want 00", {done, busy}); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_multi_kernel();
    bit ok;
    int r0, d0, w0;
    r0 = rd_cnt; d0 = done_cnt; w0 = win_cnt;
    base_addr = 10'h010; num_kernels = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    compute_done = 1'b1;   // outside READY, must be ignored
    tick();
    compute_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL multi_valid_timeout[%0d]: got %b want 1", k, ok); end
      repeat (5) tick();
      checks++; if (wgt_valid !== 1'b1) begin errors++; $display("FAIL multi_hold[%0d]: got %b want 1", k, wgt_valid); end
      checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL multi_early_done[%0d]: got %0d want 0", k, done_cnt - d0); end
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b want 1", done); end
    checks++; if ({sbuf[3], sbuf[2], sbuf[1], sbuf[0]} !== 32'h18191A1B) begin errors++; $display("FAIL multi_buffer: got %h want 18191a1b", {sbuf[3], sbuf[2], sbuf[1], sbuf[0]}); end
    tick();
    checks++; if (rd_cnt - r0 !== 12) begin errors++; $display("FAIL multi_read_count: got %0d want 12", rd_cnt - r0); end
    checks++; if (win_cnt - w0 !== 3) begin errors++; $display("FAIL multi_windows: got %0d want 3", win_cnt - w0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL multi_done_count: got %0d want 1", done_cnt - d0); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (addr_hist[(r0 + i) % 64] !== 10'h010 + 10'(i)) begin errors++; $display("FAIL multi_addr[%0d]: got %h want %h", i, addr_hist[(r0 + i) % 64], 10'h010 + 10'(i)); end
    end
  endtask

  task automatic test_zero_kernels();
    int r0, d0;
    r0 = rd_cnt; d0 = done_cnt;
    base_addr = 10'h055; num_kernels = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({done, mem_rd_en, busy} !== 3'b101) begin errors++; $display("FAIL zero_done: got %b want 101", {done, mem_rd_en, busy}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_after: got %b want 00", {done, busy}); end
    repeat (3) tick();
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", rd_cnt - r0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [9:0] exp_addr [4];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    base_addr = 10'h3FE; num_kernels = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_rd_en, mem_addr} !== {1'b1, exp_addr[i]}) begin errors++; $display("FAIL wrap_addr[%0d]: got %b/%h want 1/%h", i, mem_rd_en, mem_addr, exp_addr[i]); end
      tick();
    end
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_valid_timeout: got %b want 1", ok); end
    checks++; if ({sbuf[3], sbuf[2], sbuf[1], sbuf[0]} !== 32'hFEFF0001) begin errors++; $display("FAIL wrap_buffer: got %h want feff0001", {sbuf[3], sbuf[2], sbuf[1], sbuf[0]}); end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    int r0, d0;
    r0 = rd_cnt; d0 = done_cnt;
    base_addr = 10'h020; num_kernels = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_addr !== 10'h020) begin errors++; $display("FAIL abort_fetch1: got %h want 020", mem_addr); end
    tick();
    checks++; if (mem_addr !== 10'h021) begin errors++; $display("FAIL abort_fetch2: got %h want 021", mem_addr); end
    abort = 1'b1; start = 1'b1; base_addr = 10'h100; num_kernels = 8'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++; if ({busy, mem_rd_en, wgt_read, wgt_valid, done} !== 5'b00000) begin errors++; $display("FAIL abort_idle: got %b want 00000", {busy, mem_rd_en, wgt_read, wgt_valid, done}); end
    repeat (8) tick();
    checks++; if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL abort_reads: got %0d want 2", rd_cnt - r0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    base_addr = 10'h030; num_kernels = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_rd_en, mem_addr} !== {1'b1, 10'h030 + 10'(i)}) begin errors++; $display("FAIL restart_addr[%0d]: got %b/%h want 1/%h", i, mem_rd_en, mem_addr, 10'h030 + 10'(i)); end
      tick();
    end
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_valid_timeout: got %b want 1", ok); end
    checks++; if ({sbuf[3], sbuf[2], sbuf[1], sbuf[0]} !== 32'h30313233) begin errors++; $display("FAIL restart_buffer: got %h want 30313233", {sbuf[3], sbuf[2], sbuf[1], sbuf[0]}); end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0, d0;
    r0 = rd_cnt; d0 = done_cnt;
    base_addr = 10'h040; num_kernels = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mem_addr !== 10'h040) begin errors++; $display("FAIL rstmid_fetch1: got %h want 040", mem_addr); end
    start = 1'b1; base_addr = 10'h100; num_kernels = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (mem_addr !== 10'h040 + 10'(i)) begin errors++; $display("FAIL rstmid_ignored_start[%0d]: got %h want %h", i, mem_addr, 10'h040 + 10'(i)); end
      tick();
    end
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_valid_timeout: got %b want 1", ok); end
    rst_n = 1'b0;
    tick();
    checks++; if ({mem_rd_en, wgt_read, wgt_valid, busy, done} !== 5'b00000) begin errors++; $display("FAIL rstmid_flags: got %b want 00000", {mem_rd_en, wgt_read, wgt_valid, busy, done}); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL rstmid_addr: got %h want 000", mem_addr); end
    checks++; if (wgt_input !== mem_rdata) begin errors++; $display("FAIL rstmid_wgt_input: got %h want %h", wgt_input, mem_rdata); end
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stay_idle: got %b want 0", busy); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (rd_cnt - r0 !== 4) begin errors++; $display("FAIL rstmid_reads: got %0d want 4", rd_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_single_kernel();
    test_multi_kernel();
    test_zero_kernels();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wgt_load_ctrl.md
WGT_LOAD_CTRL -- requirements
Module: wgt_load_ctrl

Interface
REQ-001 Parameters SHALL be one per line:
  ADDR_W, 10, weight-memory address width
  KCNT_W, 8, kernel-count width
  WGT_DEPTH, 4, weights per kernel (equals weight shift-buffer depth)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  synchronous active-low reset
  start  in  1  one-cycle pulse, begins a load sequence
  base_addr  in  ADDR_W  first weight address, sampled on accepted start
  num_kernels  in  KCNT_W  kernels to load, sampled on accepted start
  abort  in  1  synchronous cancel of current sequence
  compute_done  in  1  compute array has consumed the current kernel
  mem_rd_en  out  1  weight-memory read strobe
  mem_addr  out  ADDR_W  weight-memory read address
  mem_rdata  in  8 signed  read data, valid exactly 1 cycle after mem_rd_en
  wgt_read  out  1  shift enable to weight shift buffer
  wgt_input  out  8 signed  shift data to weight shift buffer
  wgt_valid  out  1  buffer holds a complete kernel
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle pulse when all kernels consumed

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DRAIN, READY, DONE.
REQ-004 IDLE: start=1 SHALL latch base_addr/num_kernels, clear kernel counter and word counter, go to FETCH; if num_kernels=0 go to DONE instead.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 FETCH SHALL last exactly WGT_DEPTH cycles, mem_rd_en=1 each cycle, mem_addr = base + kernel_idx*WGT_DEPTH + word_idx, word_idx 0..WGT_DEPTH-1.
REQ-007 Address arithmetic SHALL be modulo 2^ADDR_W (wraps, no error).
REQ-008 wgt_read SHALL equal mem_rd_en delayed one cycle (registered); wgt_input SHALL be mem_rdata combinationally; thus wgt_read is high for WGT_DEPTH consecutive cycles starting one cycle after the first read.
REQ-009 After the last FETCH cycle the FSM SHALL enter DRAIN for one cycle (last shift occurs), then READY.
REQ-010 Word at offset 0 SHALL end in buffer stage WGT_DEPTH-1, offset WGT_DEPTH-1 in stage 0.
REQ-011 READY: wgt_valid=1, wgt_read=0, mem_rd_en=0; hold until compute_done=1.
REQ-012 READY with compute_done: increment kernel_idx; if kernel_idx+1 < num_kernels go to FETCH (next cycle issues first read), else go to DONE.
REQ-013 compute_done outside READY SHALL be ignored.
REQ-014 DONE SHALL last one cycle with done=1, then IDLE; done SHALL not assert after abort.
REQ-015 abort=1 in any state SHALL go to IDLE next cycle, dropping mem_rd_en, wgt_read, wgt_valid; abort has priority over start and compute_done in the same cycle.
REQ-016 mem_addr SHALL be 0 when mem_rd_en=0.

Reset
REQ-017 rst_n=0 at a rising clk edge SHALL force IDLE, all counters and latched inputs to 0, and mem_rd_en, mem_addr, wgt_read, wgt_valid, busy, done to 0; wgt_input follows mem_rdata.
REQ-018 Reset mid-sequence SHALL behave as abort; no done pulse.

Structure
REQ-019 FSM state encoding and WGT_DEPTH default SHALL live in shared package cnn_pkg.
REQ-020 Block SHALL be a single module with no sub-modules; it instantiates neither memory nor shift buffer.

Verification
REQ-021 start, base=0x010, num_kernels=1, memory word = address[7:0] -> reads 0x010..0x013 in 4 cycles, wgt_read cycles 2-5, buffer stage3..0 = 0x10,0x11,0x12,0x13, wgt_valid held until compute_done, then one done pulse.
REQ-022 num_kernels=3, compute_done delayed 5 cycles each -> addresses 0x010..0x01B strictly sequential, exactly 3 wgt_valid windows, done once after third compute_done.
REQ-023 num_kernels=0 -> no mem_rd_en, done one cycle after start.
REQ-024 base=0x3FE, num_kernels=1 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-025 abort on 2nd FETCH cycle with coincident start -> IDLE next cycle, no further reads, no done; a subsequent start restarts cleanly.
REQ-026 rst_n low while READY and start pulse during FETCH -> reset values per REQ-017; ignored start causes no address change.
